mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow memory between I- and D-cache; registered outputs,
// >=3 cycles request-to-ready; losing port simply holds its request until served.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [15:0]       busy_cnt
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic                gnt_d_q, gnt_d_d;
   logic                last_d_q, last_d_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;
   logic [15:0]         busy_q, busy_d;

   logic i_req, d_req, pick_d;
   assign i_req  = i_read | i_write;
   assign d_req  = d_read | d_write;
   // On a tie the side that did not own the previous transaction wins
   assign pick_d = d_req & (~i_req | ~last_d_q);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_req || d_req) state_d = ACCESS;
         ACCESS:  if (mem_ready)      state_d = RESP;
         RESP:                        state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d_d     = gnt_d_q;
      last_d_d    = last_d_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      busy_d      = (state_q != IDLE && busy_q != 16'hFFFF) ? busy_q + 16'd1 : busy_q;
      case (state_q)
         IDLE: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (i_req || d_req) begin
               gnt_d_d = pick_d;
               // A write wins over a read raised on the same port
               if (pick_d) begin
                  mem_write_d = d_write;
                  mem_read_d  = ~d_write;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  mem_write_d = i_write;
                  mem_read_d  = ~i_write;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = i_wdata;
               end
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (gnt_d_q) begin
                  d_rdata_d = mem_rdata;
                  d_ready_d = 1'b1;
               end else begin
                  i_rdata_d = mem_rdata;
                  i_ready_d = 1'b1;
               end
            end
         end
         RESP:    last_d_d = gnt_d_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_d_q     <= 1'b0;
         last_d_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         busy_q      <= 16'd0;
      end else begin
         gnt_d_q     <= gnt_d_d;
         last_d_q    <= last_d_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;
   assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model and directed scenarios.
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_read = 1'b0, i_write = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_wdata = '0;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          d_read = 1'b0, d_write = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic [15:0]   busy_cnt;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      bit            on_d;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   txn_t          cur;
   bit            model_ok = 0;
   bit            in_flight = 0;   // a transaction owns the memory or is responding
   bit            answered = 0;    // memory has completed the current transaction
   bit            last_was_d = 0;
   bit            e_mrd = 0, e_mwr = 0, e_irdy = 0, e_drdy = 0;
   bit            i_known = 1, d_known = 1;
   logic [AW-1:0] e_maddr = '0;
   logic [DW-1:0] e_mwdata = '0, e_irdata = '0, e_drdata = '0;
   logic [15:0]   e_busy = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         model_ok = 1; in_flight = 0; answered = 0; last_was_d = 0;
         e_mrd = 0; e_mwr = 0; e_irdy = 0; e_drdy = 0;
         e_maddr = '0; e_mwdata = '0; e_irdata = '0; e_drdata = '0;
         i_known = 1; d_known = 1; e_busy = '0;
      end else begin
         if (in_flight && e_busy != 16'hFFFF) e_busy = e_busy + 16'd1;
         e_irdy = 0; e_drdy = 0;
         if (!in_flight) begin
            if (i_read || i_write || d_read || d_write) begin
               cur.on_d = (d_read || d_write) && !((i_read || i_write) && last_was_d);
               cur.wr   = cur.on_d ? d_write : i_write;
               cur.addr = cur.on_d ? d_addr  : i_addr;
               cur.data = cur.on_d ? d_wdata : i_wdata;
               in_flight = 1; answered = 0;
               e_mrd = !cur.wr; e_mwr = cur.wr;
               e_maddr = cur.addr; e_mwdata = cur.data;
            end
         end else if (!answered) begin
            if (mem_ready) begin
               answered = 1; e_mrd = 0; e_mwr = 0;
               if (cur.on_d) begin e_drdata = mem_rdata; d_known = !cur.wr; e_drdy = 1; end
               else          begin e_irdata = mem_rdata; i_known = !cur.wr; e_irdy = 1; end
            end
         end else begin
            last_was_d = cur.on_d;
            in_flight = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("mem_read", 128'(mem_read), 128'(e_mrd));
         chk("mem_write", 128'(mem_write), 128'(e_mwr));
         chk("i_ready", 128'(i_ready), 128'(e_irdy));
         chk("d_ready", 128'(d_ready), 128'(e_drdy));
         chk("busy_cnt", 128'(busy_cnt), 128'(e_busy));
         if (e_mrd || e_mwr) begin
            chk("mem_addr", 128'(mem_addr), 128'(e_maddr));
            chk("mem_wdata", mem_wdata, e_mwdata);
         end
         if (i_known) chk("i_rdata", i_rdata, e_irdata);
         if (d_known) chk("d_rdata", d_rdata, e_drdata);
      end
   end

   // ---------------- stimulus and literal expectations ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   logic [DW-1:0] pat;
   logic [DW-1:0] pat2;
   int cnt_rd, cnt_ir, cnt_dr, cnt_wr, waited;
   bit got;

   initial begin
      pat  = {16{8'hA5}};
      pat2 = {16{8'h77}};
      tick();
      do_reset();

      // Idle after reset: everything quiet
      for (int c = 0; c < 20; c++) tick();
      chk("idle mem_read", 128'(mem_read), 128'd0);
      chk("idle mem_write", 128'(mem_write), 128'd0);
      chk("idle mem_addr", 128'(mem_addr), 128'd0);
      chk("idle mem_wdata", mem_wdata, 128'd0);
      chk("idle readies", 128'({i_ready, d_ready}), 128'd0);
      chk("idle rdata", i_rdata | d_rdata, 128'd0);
      chk("idle busy", 128'(busy_cnt), 128'd0);

      // Single I read, memory answers in the 4th access cycle
      i_read = 1; i_addr = 28'h0000010;
      cnt_rd = 0; cnt_ir = 0; cnt_dr = 0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (mem_read) cnt_rd++;
         if (i_ready) cnt_ir++;
         if (d_ready) cnt_dr++;
         if (c == 1) chk("i read addr", 128'(mem_addr), 128'h10);
         if (c == 4) begin mem_ready = 1; mem_rdata = pat; end
         else mem_ready = 0;
         if (c == 5) begin chk("i_rdata A5", i_rdata, pat); i_read = 0; end
      end
      chk("mem_read cycles", 128'(cnt_rd), 128'd4);
      chk("i_ready pulses", 128'(cnt_ir), 128'd1);
      chk("d_ready pulses", 128'(cnt_dr), 128'd0);
      chk("busy after read", 128'(busy_cnt), 128'd5);

      // Simultaneous requests: D first, then I on the next tie, then D again
      do_reset();
      d_write = 1; d_addr = 28'h0000020; d_wdata = 128'h1234;
      i_read = 1;  i_addr = 28'h0000030;
      tick();
      chk("tie1 mem_write", 128'({mem_write, mem_read}), 128'b10);
      chk("tie1 addr", 128'(mem_addr), 128'h20);
      chk("tie1 wdata", mem_wdata, 128'h1234);
      mem_ready = 1;
      tick();
      mem_ready = 0;
      chk("tie1 ready", 128'({i_ready, d_ready}), 128'b01);
      tick();
      chk("idle between", 128'({mem_write, mem_read}), 128'b00);
      tick();
      chk("tie2 I read", 128'({mem_write, mem_read}), 128'b01);
      chk("tie2 addr", 128'(mem_addr), 128'h30);
      mem_ready = 1; mem_rdata = pat2;
      tick();
      mem_ready = 0;
      chk("tie2 ready", 128'({i_ready, d_ready}), 128'b10);
      chk("tie2 rdata", i_rdata, pat2);
      i_read = 0;
      tick();
      tick();
      chk("waiting D served", 128'({mem_write, mem_read}), 128'b10);
      chk("waiting D addr", 128'(mem_addr), 128'h20);
      mem_ready = 1;
      tick();
      mem_ready = 0;
      chk("waiting D ready", 128'(d_ready), 128'd1);
      d_write = 0;
      tick();

      // Read and write together on D: only a write is issued
      d_read = 1; d_write = 1; d_addr = 28'h0000040; d_wdata = 128'hBEEF;
      cnt_wr = 0; cnt_rd = 0; cnt_dr = 0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (mem_write) cnt_wr++;
         if (mem_read) cnt_rd++;
         if (d_ready) begin cnt_dr++; d_read = 0; d_write = 0; end
         mem_ready = (c == 3);
      end
      chk("rw write cycles", 128'(cnt_wr), 128'd3);
      chk("rw read cycles", 128'(cnt_rd), 128'd0);
      chk("rw d_ready pulses", 128'(cnt_dr), 128'd1);

      // Reset in the middle of an access abandons it
      i_read = 1; i_addr = 28'h0000050;
      tick();
      tick();
      chk("pre-reset strobe", 128'(mem_read), 128'd1);
      rst_n = 0; i_read = 0;
      tick();
      rst_n = 1;
      chk("post-reset strobes", 128'({mem_write, mem_read}), 128'd0);
      chk("post-reset busy", 128'(busy_cnt), 128'd0);
      cnt_ir = 0;
      for (int c = 0; c < 4; c++) begin tick(); if (i_ready) cnt_ir++; end
      chk("no ready after reset", 128'(cnt_ir), 128'd0);
      i_read = 1; i_addr = 28'h0000060; mem_ready = 1; mem_rdata = pat;
      got = 0; waited = 0;
      while (!got && waited < 20) begin
         tick(); waited++;
         if (i_ready) got = 1;
      end
      chk("read after reset done", 128'(got), 128'd1);
      chk("read after reset data", i_rdata, pat);
      i_read = 0; mem_ready = 0;
      tick();

      // Randomized traffic, model checks every cycle
      for (int c = 0; c < 4000; c++) begin
         tick();
         rst_n     = ($urandom_range(0, 249) != 0);
         i_read    = ($urandom_range(0, 9) < 3);
         i_write   = ($urandom_range(0, 9) < 2);
         d_read    = ($urandom_range(0, 9) < 3);
         d_write   = ($urandom_range(0, 9) < 2);
         i_addr    = AW'($urandom());
         d_addr    = AW'($urandom());
         i_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
         d_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
         mem_ready = ($urandom_range(0, 2) == 0);
         mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      rst_n = 1; i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_ready = 0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
